// File: rtl/booth_multiplier.sv
// Sequential radix-2 Booth signed multiplier.
// One add/subtract step per clock followed by an arithmetic shift right of
// the {U, V} pair; WIDTH iterations produce the exact 2*WIDTH-bit product.
module booth_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 op_start,
    input  logic                 op_clear,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 op_busy,
    output logic                 op_done,
    output logic [2*WIDTH-1:0]   result
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  m_reg, m_next;
    logic [WIDTH:0]    u_reg, u_next;      // one guard bit so U-M never overflows
    logic [WIDTH-1:0]  v_reg, v_next;
    logic              x_prev_reg, x_prev_next;
    logic [CW-1:0]     count_reg, count_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;

    logic [WIDTH:0]    m_ext;
    logic [WIDTH:0]    t_sum;
    logic              last_iter;

    assign m_ext     = {m_reg[WIDTH-1], m_reg};
    assign last_iter = (count_reg == CW'(WIDTH - 1));

    // Booth recoding of {V[0], x_prev}: add, subtract or pass the accumulator
    always_comb begin
        t_sum = u_reg;
        case ({v_reg[0], x_prev_reg})
            2'b01:   t_sum = u_reg + m_ext;
            2'b10:   t_sum = u_reg - m_ext;
            default: t_sum = u_reg;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; clear overrides every other request
    always_comb begin
        state_next = state_reg;
        if (op_clear) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (op_start) state_next = EXEC;
                EXEC:    if (last_iter) state_next = DONE;
                DONE:    state_next = DONE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Output decode, taken from the next state so the flags are registered
    always_comb begin
        busy_next = (state_next == EXEC);
        done_next = (state_next == DONE);
    end

    // Datapath next values: latch on start, iterate in EXEC, hold otherwise
    always_comb begin
        m_next      = m_reg;
        u_next      = u_reg;
        v_next      = v_reg;
        x_prev_next = x_prev_reg;
        count_next  = count_reg;
        if (op_clear) begin
            m_next      = '0;
            u_next      = '0;
            v_next      = '0;
            x_prev_next = 1'b0;
            count_next  = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (op_start) begin
                        m_next      = multiplicand;
                        u_next      = '0;
                        v_next      = multiplier;
                        x_prev_next = 1'b0;
                        count_next  = '0;
                    end
                end
                EXEC: begin
                    u_next      = {t_sum[WIDTH], t_sum[WIDTH:1]};
                    v_next      = {t_sum[0], v_reg[WIDTH-1:1]};
                    x_prev_next = v_reg[0];
                    count_next  = count_reg + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Datapath and flag registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_reg      <= '0;
            u_reg      <= '0;
            v_reg      <= '0;
            x_prev_reg <= 1'b0;
            count_reg  <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            m_reg      <= m_next;
            u_reg      <= u_next;
            v_reg      <= v_next;
            x_prev_reg <= x_prev_next;
            count_reg  <= count_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
        end
    end

    assign op_busy = busy_reg;
    assign op_done = done_reg;
    assign result  = {u_reg[WIDTH-1:0], v_reg};

endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier: directed corner cases plus
// random operand pairs compared against a plain signed multiply.
module tb_booth_multiplier;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        op_start;
    logic        op_clear;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        op_busy;
    logic        op_done;
    logic [63:0] result;

    int errors = 0;
    int checks = 0;

    booth_multiplier #(.WIDTH(32)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .op_start     (op_start),
        .op_clear     (op_clear),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .op_busy      (op_busy),
        .op_done      (op_done),
        .result       (result)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start an operation, scramble inputs while it runs, then check the product
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input string tag);
        int n;
        logic [63:0] exp;
        exp = ref_mul(a, b);
        multiplicand = a;
        multiplier   = b;
        op_start     = 1'b1;
        step();
        op_start = 1'b0;
        check({tag, ".busy_at_start"}, {63'd0, op_busy}, 64'd1);
        n = 0;
        while (op_busy && n < 100) begin
            n++;
            multiplicand = $urandom;
            multiplier   = $urandom;
            op_start     = 1'($urandom_range(0, 1));
            step();
        end
        op_start = 1'b0;
        check({tag, ".busy_cycles"}, 64'(n), 64'd32);
        check({tag, ".done"}, {63'd0, op_done}, 64'd1);
        check({tag, ".result"}, result, exp);
        $display("op %s: 0x%h * 0x%h -> 0x%h (ref 0x%h) busy_cycles=%0d", tag, a, b, result, exp, n);
    endtask

    task automatic clear_op(input string tag);
        op_clear = 1'b1;
        step();
        op_clear = 1'b0;
        check({tag, ".clr_result"}, result, 64'd0);
        check({tag, ".clr_done"}, {63'd0, op_done}, 64'd0);
    endtask

    initial begin
        logic [63:0] held;
        reset_n      = 1'b0;
        op_start     = 1'b0;
        op_clear     = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        step();
        step();
        check("reset.result", result, 64'd0);
        check("reset.busy", {63'd0, op_busy}, 64'd0);
        check("reset.done", {63'd0, op_done}, 64'd0);
        reset_n = 1'b1;
        step();

        // 3 x 5
        run_op(32'd3, 32'd5, "3x5");
        check("3x5.const", result, 64'h0000_0000_0000_000F);
        clear_op("3x5");

        // -7 x 6, then DONE must hold through start pulses
        run_op(32'hFFFF_FFF9, 32'd6, "m7x6");
        check("m7x6.const", result, 64'hFFFF_FFFF_FFFF_FFD6);
        held = result;
        for (int i = 0; i < 10; i++) begin
            op_start = i[0];
            step();
            check("done_hold.done", {63'd0, op_done}, 64'd1);
            check("done_hold.result", result, held);
        end
        op_start = 1'b0;
        check("done_hold.busy", {63'd0, op_busy}, 64'd0);
        clear_op("m7x6");

        // Most negative operand corners
        run_op(32'h8000_0000, 32'h8000_0000, "min_x_min");
        check("min_x_min.const", result, 64'h4000_0000_0000_0000);
        clear_op("min_x_min");
        run_op(32'h8000_0000, 32'h7FFF_FFFF, "min_x_max");
        check("min_x_max.const", result, 64'hC000_0000_8000_0000);
        clear_op("min_x_max");

        // Clear in the middle of EXEC aborts the operation
        multiplicand = 32'h1234_5678;
        multiplier   = 32'h9ABC_DEF0;
        op_start     = 1'b1;
        step();
        op_start = 1'b0;
        repeat (9) step();
        check("abort.busy_before", {63'd0, op_busy}, 64'd1);
        op_clear = 1'b1;
        step();
        op_clear = 1'b0;
        check("abort.result", result, 64'd0);
        check("abort.busy", {63'd0, op_busy}, 64'd0);
        check("abort.done", {63'd0, op_done}, 64'd0);
        step();
        check("abort.stays_idle", {63'd0, op_busy}, 64'd0);
        run_op(32'd2, 32'hFFFF_FFFF, "2xm1");
        check("2xm1.const", result, 64'hFFFF_FFFF_FFFF_FFFE);
        clear_op("2xm1");

        // Asynchronous reset between edges in EXEC
        multiplicand = 32'h0BAD_F00D;
        multiplier   = 32'h0123_4567;
        op_start     = 1'b1;
        step();
        op_start = 1'b0;
        repeat (5) step();
        #2;
        reset_n = 1'b0;
        #1;
        check("areset.result", result, 64'd0);
        check("areset.busy", {63'd0, op_busy}, 64'd0);
        check("areset.done", {63'd0, op_done}, 64'd0);
        step();
        reset_n = 1'b1;
        step();
        run_op(32'hFFFF_FF00, 32'h0000_1234, "after_reset");
        clear_op("after_reset");

        // Clear and start on the same edge: nothing begins
        multiplicand = 32'd9;
        multiplier   = 32'd9;
        op_clear     = 1'b1;
        op_start     = 1'b1;
        step();
        op_clear = 1'b0;
        op_start = 1'b0;
        check("clr_start.busy", {63'd0, op_busy}, 64'd0);
        check("clr_start.result", result, 64'd0);
        step();
        check("clr_start.still_idle", {63'd0, op_busy | op_done}, 64'd0);

        // Latched operands survive input changes during EXEC
        run_op(32'd100, 32'hFFFF_FF9C, "100xm100");
        check("100xm100.const", result, 64'hFFFF_FFFF_FFFF_D8F0);
        clear_op("100xm100");

        // Random operand pairs
        for (int i = 0; i < 12; i++) begin
            run_op($urandom, $urandom, $sformatf("rand%0d", i));
            clear_op($sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/booth_multiplier.md
Name: booth_multiplier

Overview:
- Sequential radix-2 Booth signed multiplier for the Top datapath.
- Performs one Booth add/subtract step per clock, followed by a 1-bit arithmetic shift right of the {accumulator, multiplier} pair, which is the same ASR32 shift semantics the shifter stage provides.
- Consumes two signed operands from the bus/register stage and produces a 64-bit signed product for the result register.

Parameters:
- WIDTH, 32, operand width in bits; the product is 2*WIDTH bits and the iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- op_start  input  1  start request; sampled only in IDLE
- op_clear  input  1  synchronous clear to IDLE; highest priority after reset
- multiplicand  input  WIDTH  signed operand M; latched at start
- multiplier  input  WIDTH  signed operand X; latched at start
- op_busy  output  1  high while in EXEC
- op_done  output  1  high while in DONE
- result  output  2*WIDTH  product register {U,V}; holds the running partial product during EXEC and the final product in DONE

Behaviour:
- Reset (reset_n=0, asynchronous, any state):
  - state=IDLE, count=0, M=0, U=0, V=0, x_prev=0.
  - result=0, op_busy=0, op_done=0.
- Internal registers:
  - M: WIDTH bits.
  - U: WIDTH+1 bits, sign-extended, so that U−M cannot overflow when M=−2^(WIDTH−1).
  - V: WIDTH bits; it holds X and fills with product low bits as X is shifted out.
  - x_prev: 1 bit.
  - count: clog2(WIDTH) bits.
- result = {U[WIDTH−1:0], V}.
- States: IDLE, EXEC, DONE. Two-bit encoding, free choice.
- IDLE:
  - op_start=1 → latch M=multiplicand, V=multiplier, U=0, x_prev=0, count=0; go to EXEC.
  - Otherwise hold.
- EXEC: one iteration per edge.
  - Select on {V[0], x_prev}:
    - 01 → T=U+M.
    - 10 → T=U−M.
    - 00 or 11 → T=U.
    - M is sign-extended to WIDTH+1 bits.
  - Shift: {U,V} ← ASR-by-1 of {T,V}. T's MSB is replicated into U's MSB, T[0] enters V[WIDTH−1], and x_prev ← old V[0].
  - count increments.
  - If count==WIDTH−1 on this edge → go to DONE.
  - Exactly WIDTH iterations are performed.
- Latency: start sampled at edge k; iterations occur at edges k+1..k+WIDTH; op_done=1 after edge k+WIDTH (32 cycles for WIDTH=32).
- DONE:
  - op_done=1 and result is held stable.
  - op_start is ignored.
  - Only op_clear (or reset) leaves DONE → IDLE.
- op_busy=1 iff state==EXEC. op_done=1 iff state==DONE. Both are registered decodes of state.
- op_clear=1 at any edge, in any state:
  - state=IDLE, and U, V, M, count, x_prev are cleared, so result=0.
  - Overrides op_start on the same edge.
  - Clears mid-EXEC abort the operation with no partial result kept.
- op_start in EXEC or DONE: ignored. Operand input changes after the start edge: ignored.
- Arithmetic: two's complement throughout. The full 2*WIDTH product is exact for all operand pairs, including (−2^31)×(−2^31).

Test Plan:
- Reset, then multiplicand=3, multiplier=5, op_start for 1 cycle → op_busy=1 for exactly 32 cycles; op_done=1 after edge 32; result=0x0000_0000_0000_000F.
- multiplicand=−7 (0xFFFF_FFF9), multiplier=6 → result=0xFFFF_FFFF_FFFF_FFD6; op_done held for 10 idle cycles while op_start pulses, result unchanged.
- multiplicand=0x8000_0000, multiplier=0x8000_0000 → result=0x4000_0000_0000_0000. Also 0x8000_0000 × 0x7FFF_FFFF → 0xC000_0000_8000_0000 (checks the WIDTH+1 accumulator).
- Start 0x1234_5678 × 0x9ABC_DEF0, assert op_clear at EXEC iteration 10 → next cycle state IDLE, result=0, op_busy=0, op_done=0. Restart with 2×−1 → result=0xFFFF_FFFF_FFFF_FFFE.
- Mid-EXEC: drop reset_n asynchronously between clock edges → result=0, op_busy=0 immediately without a clock edge. After release, a new start completes normally.
- Same edge: op_clear=1 and op_start=1 in IDLE → stays IDLE and no operation begins. Operands changed during EXEC do not alter the product of the latched 100×−100 = 0xFFFF_FFFF_FFFF_D8F0.
